// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: bundles the EX-stage request, the HI/LO view and the
// multiplier/divider handshakes of muldiv_ctrl.
//   slave  : controller side (muldiv_ctrl)
//   master : environment side (EX stage + multiply/divide units)
// Signal names keep their original _i/_o suffixes, seen from the controller.
interface muldiv_ctrl_if #(
  parameter int OPW = 4
);
  logic           flush;
  logic           op_valid_i;
  logic [OPW-1:0] op_i;
  logic [31:0]    rs_i;
  logic [31:0]    rt_i;
  logic           stall_o;
  logic           done_o;
  logic [31:0]    mul_lo_o;
  logic [31:0]    hi_o;
  logic [31:0]    lo_o;
  logic           mult_start_o;
  logic           mult_signed_o;
  logic [31:0]    mult_a_o;
  logic [31:0]    mult_b_o;
  logic           mult_ready_i;
  logic [63:0]    mult_result_i;
  logic           div_start_o;
  logic           div_signed_o;
  logic [31:0]    div_a_o;
  logic [31:0]    div_b_o;
  logic           div_ready_i;
  logic [63:0]    div_result_i;
  logic           unit_flush_o;

  modport slave (
    input  flush, op_valid_i, op_i, rs_i, rt_i,
    input  mult_ready_i, mult_result_i, div_ready_i, div_result_i,
    output stall_o, done_o, mul_lo_o, hi_o, lo_o,
    output mult_start_o, mult_signed_o, mult_a_o, mult_b_o,
    output div_start_o, div_signed_o, div_a_o, div_b_o, unit_flush_o
  );

  modport master (
    output flush, op_valid_i, op_i, rs_i, rt_i,
    output mult_ready_i, mult_result_i, div_ready_i, div_result_i,
    input  stall_o, done_o, mul_lo_o, hi_o, lo_o,
    input  mult_start_o, mult_signed_o, mult_a_o, mult_b_o,
    input  div_start_o, div_signed_o, div_a_o, div_b_o, unit_flush_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one HI/LO-class instruction at a time between the EX
// stage and the multi-cycle multiplier/divider, stalls EX until the unit's
// ready pulse, then writes HI/LO (plain, accumulate or MUL GPR-only result).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : muldiv_ctrl_if.slave -- EX request (op_valid_i/op_i/rs_i/rt_i,
//              flush), stall_o/done_o/mul_lo_o, HI/LO outputs, multiplier and
//              divider start/operand/ready/result handshakes, unit_flush_o.
module muldiv_ctrl #(
  parameter int OPW = 4
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_ctrl_if.slave bus
);

  typedef enum logic [OPW-1:0] {
    OP_NOP   = OPW'(0),
    OP_MULT  = OPW'(1),
    OP_MULTU = OPW'(2),
    OP_DIV   = OPW'(3),
    OP_DIVU  = OPW'(4),
    OP_MADD  = OPW'(5),
    OP_MADDU = OPW'(6),
    OP_MSUB  = OPW'(7),
    OP_MSUBU = OPW'(8),
    OP_MTHI  = OPW'(9),
    OP_MTLO  = OPW'(10),
    OP_MUL   = OPW'(11)
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MWAIT,
    ST_DWAIT,
    ST_ACC,
    ST_DONE
  } state_e;

  state_e      state_q, state_d;
  op_e         op_in, op_q;

  logic [31:0] hi_q, lo_q, mul_lo_q;
  logic [63:0] prod_q;
  logic        mult_start_q, mult_signed_q, div_start_q, div_signed_q;
  logic [31:0] mult_a_q, mult_b_q, div_a_q, div_b_q;

  // Per-cycle actions decided by the FSM
  logic accept_mul, accept_div, wr_hi, wr_lo;
  logic mult_ld_hilo, mult_ld_mullo, mult_ld_prod, acc_do, div_ld_hilo;
  logic stall, done;

  assign op_in = op_e'(bus.op_i);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    accept_mul    = 1'b0;
    accept_div    = 1'b0;
    wr_hi         = 1'b0;
    wr_lo         = 1'b0;
    mult_ld_hilo  = 1'b0;
    mult_ld_mullo = 1'b0;
    mult_ld_prod  = 1'b0;
    acc_do        = 1'b0;
    div_ld_hilo   = 1'b0;
    stall         = 1'b0;
    done          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.op_valid_i) begin
          case (op_in)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU, OP_MUL: begin
              stall      = 1'b1;
              accept_mul = 1'b1;
              state_d    = ST_MWAIT;
            end
            OP_DIV, OP_DIVU: begin
              stall = 1'b1;
              // Divide by zero never reaches the divider; retire via DONE
              // with HI/LO untouched.
              if (bus.rt_i == '0) begin
                state_d = ST_DONE;
              end else begin
                accept_div = 1'b1;
                state_d    = ST_DWAIT;
              end
            end
            OP_MTHI: wr_hi = 1'b1;
            OP_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MWAIT: begin
        stall = 1'b1;
        if (bus.mult_ready_i) begin
          case (op_q)
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              mult_ld_prod = 1'b1;
              state_d      = ST_ACC;
            end
            OP_MUL: begin
              mult_ld_mullo = 1'b1;
              state_d       = ST_DONE;
            end
            default: begin
              mult_ld_hilo = 1'b1;
              state_d      = ST_DONE;
            end
          endcase
        end
      end
      ST_DWAIT: begin
        stall = 1'b1;
        if (bus.div_ready_i) begin
          div_ld_hilo = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_ACC: begin
        stall   = 1'b1;
        acc_do  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides everything decided above, including a coincident
    // ready pulse or an MTHI/MTLO in the same cycle.
    if (bus.flush) begin
      state_d       = ST_IDLE;
      accept_mul    = 1'b0;
      accept_div    = 1'b0;
      wr_hi         = 1'b0;
      wr_lo         = 1'b0;
      mult_ld_hilo  = 1'b0;
      mult_ld_mullo = 1'b0;
      mult_ld_prod  = 1'b0;
      acc_do        = 1'b0;
      div_ld_hilo   = 1'b0;
      stall         = 1'b0;
      done          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q          <= OP_NOP;
      hi_q          <= '0;
      lo_q          <= '0;
      mul_lo_q      <= '0;
      prod_q        <= '0;
      mult_start_q  <= 1'b0;
      mult_signed_q <= 1'b0;
      mult_a_q      <= '0;
      mult_b_q      <= '0;
      div_start_q   <= 1'b0;
      div_signed_q  <= 1'b0;
      div_a_q       <= '0;
      div_b_q       <= '0;
    end else begin
      mult_start_q <= accept_mul;
      div_start_q  <= accept_div;
      if (accept_mul) begin
        op_q          <= op_in;
        mult_a_q      <= bus.rs_i;
        mult_b_q      <= bus.rt_i;
        mult_signed_q <= (op_in == OP_MULT) || (op_in == OP_MADD) ||
                         (op_in == OP_MSUB) || (op_in == OP_MUL);
      end
      if (accept_div) begin
        div_a_q      <= bus.rs_i;
        div_b_q      <= bus.rt_i;
        div_signed_q <= (op_in == OP_DIV);
      end
      if (wr_hi)         hi_q     <= bus.rs_i;
      if (wr_lo)         lo_q     <= bus.rs_i;
      if (mult_ld_hilo)  {hi_q, lo_q} <= bus.mult_result_i;
      if (mult_ld_mullo) mul_lo_q <= bus.mult_result_i[31:0];
      if (mult_ld_prod)  prod_q   <= bus.mult_result_i;
      if (acc_do) begin
        if ((op_q == OP_MSUB) || (op_q == OP_MSUBU))
          {hi_q, lo_q} <= {hi_q, lo_q} - prod_q;
        else
          {hi_q, lo_q} <= {hi_q, lo_q} + prod_q;
      end
      if (div_ld_hilo)   {hi_q, lo_q} <= bus.div_result_i;
    end
  end

  assign bus.stall_o       = stall;
  assign bus.done_o        = done;
  assign bus.mul_lo_o      = mul_lo_q;
  assign bus.hi_o          = hi_q;
  assign bus.lo_o          = lo_q;
  // A start pulse already registered is suppressed if flush lands on it.
  assign bus.mult_start_o  = mult_start_q & ~bus.flush;
  assign bus.mult_signed_o = mult_signed_q;
  assign bus.mult_a_o      = mult_a_q;
  assign bus.mult_b_o      = mult_b_q;
  assign bus.div_start_o   = div_start_q & ~bus.flush;
  assign bus.div_signed_o  = div_signed_q;
  assign bus.div_a_o       = div_a_q;
  assign bus.div_b_o       = div_b_q;
  assign bus.unit_flush_o  = bus.flush;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: self-checking bench for muldiv_ctrl. The bench plays the EX
// stage and both arithmetic units; HI/LO expectations come from a 64-bit
// arithmetic model of the instruction set.
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic rst;

  muldiv_ctrl_if #(.OPW(4)) bus ();

  muldiv_ctrl #(.OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_hilo;
  logic [31:0] m_mullo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mulop(input int op);
    return op inside {1, 2, 5, 6, 7, 8, 11};
  endfunction

  function automatic bit is_divop(input int op);
    return op inside {3, 4};
  endfunction

  function automatic bit mul_signed(input int op);
    return op inside {1, 5, 7, 11};
  endfunction

  function automatic logic [63:0] product(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb;
    if (mul_signed(op)) begin
      xa = {{32{a[31]}}, a};
      xb = {{32{b[31]}}, b};
    end else begin
      xa = {32'h0, a};
      xb = {32'h0, b};
    end
    return xa * xb;
  endfunction

  function automatic logic [63:0] quot_rem(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (op == 3) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic model_apply(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      1, 2:  m_hilo = product(op, a, b);
      5, 6:  m_hilo = m_hilo + product(op, a, b);
      7, 8:  m_hilo = m_hilo - product(op, a, b);
      11:    m_mullo = product(op, a, b) >> 0;
      3, 4:  if (b != 0) m_hilo = quot_rem(op, a, b);
      9:     m_hilo[63:32] = a;
      10:    m_hilo[31:0] = a;
      default: ;
    endcase
  endtask

  task automatic chk_hilo(input string tag);
    chk({tag, "_hi"}, bus.hi_o, m_hilo[63:32]);
    chk({tag, "_lo"}, bus.lo_o, m_hilo[31:0]);
  endtask

  // Presents one op from the next negedge and runs it to retirement. Returns
  // inside the DONE cycle for multi-cycle ops (op still held, as EX would).
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, input int lat);
    int ms = 0, ds = 0, stalls = 0, mstart_c = -1, dstart_c = -1, exp_stalls;
    bit done_seen = 1'b0;
    bit mr, dr;
    @(negedge clk);
    bus.op_valid_i = 1'b1;
    bus.op_i       = 4'(op);
    bus.rs_i       = a;
    bus.rt_i       = b;
    if (!(is_mulop(op) || is_divop(op))) begin
      #1;
      chk("single_stall", bus.stall_o, 0);
      model_apply(op, a, b);
      @(negedge clk);
      bus.op_valid_i = 1'b0;
      #1;
      chk_hilo("single");
    end else begin
      for (int c = 0; c < 60 && !done_seen; c++) begin
        if (c > 0) @(negedge clk);
        mr = (mstart_c >= 0) && (c == mstart_c + lat);
        dr = (dstart_c >= 0) && (c == dstart_c + lat);
        bus.mult_ready_i  = mr;
        bus.mult_result_i = 64'hDEAD_BEEF_0BAD_F00D;
        if (mr) bus.mult_result_i = product(op, a, b);
        // A stray divider ready during a multiply must be ignored.
        bus.div_ready_i   = dr || mr;
        bus.div_result_i  = 64'h5A5A_1234_A5A5_4321;
        if (dr) bus.div_result_i = quot_rem(op, a, b);
        #1;
        if (c == 0) chk("accept_done_low", bus.done_o, 0);
        if (bus.stall_o) stalls++;
        if (bus.mult_start_o) begin
          ms++;
          mstart_c = c;
          chk("mult_a", bus.mult_a_o, a);
          chk("mult_b", bus.mult_b_o, b);
          chk("mult_signed", bus.mult_signed_o, mul_signed(op));
        end
        if (bus.div_start_o) begin
          ds++;
          dstart_c = c;
          chk("div_a", bus.div_a_o, a);
          chk("div_b", bus.div_b_o, b);
          chk("div_signed", bus.div_signed_o, op == 3);
        end
        if (bus.done_o) begin
          done_seen = 1'b1;
          model_apply(op, a, b);
          chk("done_stall", bus.stall_o, 0);
          chk_hilo("done");
          if (op == 11) chk("mul_lo", bus.mul_lo_o, m_mullo);
        end
      end
      bus.mult_ready_i = 1'b0;
      bus.div_ready_i  = 1'b0;
      chk("done_timeout", done_seen, 1);
      chk("mult_starts", ms, is_mulop(op) ? 1 : 0);
      chk("div_starts", ds, (is_divop(op) && b != 0) ? 1 : 0);
      if (is_divop(op) && b == 0)      exp_stalls = 1;
      else if (op inside {5, 6, 7, 8}) exp_stalls = lat + 3;
      else                             exp_stalls = lat + 2;
      chk("stall_cycles", stalls, exp_stalls);
    end
  endtask

  initial begin
    int op, lat;
    logic [31:0] a, b, hi_keep;
    rst               = 1'b1;
    bus.flush         = 1'b0;
    bus.op_valid_i    = 1'b0;
    bus.op_i          = '0;
    bus.rs_i          = '0;
    bus.rt_i          = '0;
    bus.mult_ready_i  = 1'b0;
    bus.mult_result_i = '0;
    bus.div_ready_i   = 1'b0;
    bus.div_result_i  = '0;
    m_hilo            = '0;
    m_mullo           = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hilo", {bus.hi_o, bus.lo_o}, 64'h0);
    chk("rst_mul_lo", bus.mul_lo_o, 0);
    chk("rst_starts", {bus.mult_start_o, bus.div_start_o, bus.done_o, bus.stall_o}, 0);
    chk("rst_operands", {bus.mult_a_o, bus.mult_b_o, bus.div_a_o, bus.div_b_o}, 128'h0);
    rst = 1'b0;

    // Directed plan
    run_op(1, 32'hFFFF_FFFE, 32'd3, 2);
    chk("mult_neg_hi", bus.hi_o, 32'hFFFF_FFFF);
    chk("mult_neg_lo", bus.lo_o, 32'hFFFF_FFFA);
    run_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    chk("multu_max_hi", bus.hi_o, 32'hFFFF_FFFE);
    chk("multu_max_lo", bus.lo_o, 32'h0000_0001);
    run_op(11, 32'd7, 32'd6, 3);
    chk("mul_42", bus.mul_lo_o, 32'd42);
    chk("mul_keeps_hi", bus.hi_o, 32'hFFFF_FFFE);
    run_op(9, 32'h0, 32'h0, 1);
    run_op(10, 32'hFFFF_FFFF, 32'h0, 1);
    run_op(6, 32'd1, 32'd1, 2);
    chk("maddu_carry", {bus.hi_o, bus.lo_o}, 64'h0000_0001_0000_0000);
    run_op(8, 32'd1, 32'd1, 1);
    chk("msubu_borrow", {bus.hi_o, bus.lo_o}, 64'h0000_0000_FFFF_FFFF);
    run_op(3, 32'hFFFF_FFF9, 32'd2, 2);
    chk("div_neg", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(4, 32'd5, 32'd0, 1);
    chk("divu_zero", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);

    // Flush in MWAIT with a coincident multiplier ready
    @(negedge clk);
    bus.op_valid_i = 1'b1; bus.op_i = 4'd1; bus.rs_i = 32'd9; bus.rt_i = 32'd9;
    @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    bus.mult_ready_i = 1'b1;
    bus.mult_result_i = 64'd81;
    #1;
    chk("flush_stall", bus.stall_o, 0);
    chk("flush_fwd", bus.unit_flush_o, 1);
    chk("flush_done", bus.done_o, 0);
    @(negedge clk);
    bus.flush = 1'b0; bus.mult_ready_i = 1'b0;
    bus.op_valid_i = 1'b0;
    #1;
    chk_hilo("flush_keep");
    chk("flush_idle_stall", bus.stall_o, 0);
    run_op(10, 32'h1357_9BDF, 32'h0, 1);

    // Flush discards an MTHI in the same cycle
    hi_keep = bus.hi_o;
    @(negedge clk);
    bus.op_valid_i = 1'b1; bus.op_i = 4'd9; bus.rs_i = 32'hCAFE_0001;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.op_valid_i = 1'b0;
    #1;
    chk("flush_mthi", bus.hi_o, hi_keep);

    // Flush on the start cycle suppresses the divider start
    @(negedge clk);
    bus.op_valid_i = 1'b1; bus.op_i = 4'd4; bus.rs_i = 32'd100; bus.rt_i = 32'd7;
    @(negedge clk);
    bus.flush = 1'b1; bus.op_valid_i = 1'b0;
    #1;
    chk("flush_start", bus.div_start_o, 0);
    @(negedge clk);
    bus.flush = 1'b0;

    // Back-to-back MULT then DIV, op held through stall
    run_op(1, 32'h0001_0000, 32'h0001_0000, 2);
    run_op(3, 32'd100, 32'hFFFF_FFF9, 1);

    // Reset in the middle of DWAIT
    @(negedge clk);
    bus.op_valid_i = 1'b1; bus.op_i = 4'd3; bus.rs_i = 32'd50; bus.rt_i = 32'd3;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; bus.op_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_hilo = '0; m_mullo = '0;
    #1;
    chk_hilo("rst_dwait");
    chk("rst_dwait_stall", bus.stall_o, 0);
    chk("rst_dwait_mul_lo", bus.mul_lo_o, 0);
    run_op(5, 32'hFFFF_FFFF, 32'd5, 1);

    // Randomized sequence against the model
    for (int i = 0; i < 80; i++) begin
      op  = int'($urandom_range(0, 15));
      a   = $urandom;
      b   = $urandom;
      lat = int'($urandom_range(1, 4));
      if ($urandom_range(0, 5) == 0) b = 32'h0;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 9);
      if (op == 3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      run_op(op, a, b, lat);
    end
    @(negedge clk);
    bus.op_valid_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
